param_fifo: RTL
===============

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, at least 1.
REQ-002 Parameter DEPTH, default 8: number of entries, a power of two, at least 2.
REQ-003 Parameter AF_LEVEL, default DEPTH-1: almost_full threshold, compared against data_count.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty threshold, compared against data_count.
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1: reset, asynchronous and active-low.
REQ-007 wr_en  input  1: write request for the current cycle.
REQ-008 rd_en  input  1: read request for the current cycle.
REQ-009 d_in  input  WIDTH: write data.
REQ-010 d_out  output  WIDTH: registered read data.
REQ-011 full, empty  output  1 each: occupancy flags.
REQ-012 wr_ack, wr_err, rd_ack, rd_err  output  1 each: one-cycle result pulses for the previous request.
REQ-013 data_count  output  $clog2(DEPTH)+1: number of stored entries, 0..DEPTH.
REQ-014 almost_full, almost_empty  output  1 each: present only when PARAM_FIFO_ALMOST_FLAGS_EN is defined.

Function
REQ-015 A write is accepted when wr_en=1 and the FIFO is not full: mem[wr_ptr]<=d_in, wr_ptr advances by 1 modulo DEPTH, wr_ack=1 next cycle.
REQ-016 A write while full is rejected: storage and wr_ptr are unchanged, wr_err=1 next cycle.
REQ-017 A read is accepted when rd_en=1 and the FIFO is not empty: d_out<=mem[rd_ptr] at the same edge (visible 1 cycle after the request), rd_ptr advances modulo DEPTH, rd_ack=1 next cycle.
REQ-018 A read while empty is rejected: d_out holds its value, rd_err=1 next cycle.
REQ-019 d_out holds its last value in every cycle without an accepted read.
REQ-020 wr_en=rd_en=1 and 0<count<DEPTH: both are accepted, data_count is unchanged, and wr_ack=rd_ack=1.
REQ-021 wr_en=rd_en=1 while full: the read is accepted and the write is rejected (rd_ack=1, wr_err=1), count becomes DEPTH-1.
REQ-022 wr_en=rd_en=1 while empty: the write is accepted and the read is rejected (wr_ack=1, rd_err=1), count becomes 1; the read does not bypass the new data.
REQ-023 Control is a registered state machine with states INIT, NO_OP, WRITE, WR_ERR, READ, RD_ERR, WR_RD, WR_RDERR, RD_WRERR; the next state is decoded from wr_en, rd_en and the current count each cycle.
REQ-024 The ack/err pulses are decoded from the current state, so each is high for exactly one cycle per request.
REQ-025 full=(data_count==DEPTH) and empty=(data_count==0), both derived from the data_count register.
REQ-026 Pointers wrap from DEPTH-1 to 0; data_count never exceeds DEPTH or goes below 0.

Reset
REQ-027 reset_n=0 immediately forces state=INIT, wr_ptr=rd_ptr=0, data_count=0, d_out=0, all storage entries 0, all ack/err=0, full=0, empty=1, almost_full=0 and almost_empty=1, independent of clk.
REQ-028 Reset asserted mid-operation discards all contents; the first accepted write after release lands in entry 0.

Configuration
REQ-029 With PARAM_FIFO_ALMOST_FLAGS_EN defined: almost_full=(data_count>=AF_LEVEL) and almost_empty=(data_count<=AE_LEVEL), both updating in the same cycle as data_count.
REQ-030 Without PARAM_FIFO_ALMOST_FLAGS_EN: the almost_full and almost_empty ports and their logic are absent, and all other behaviour is identical.

Structure
REQ-031 Package param_fifo_pkg holds the state enum typedef and the default WIDTH/DEPTH constants.
REQ-032 Storage is the sub-module param_fifo_regbank: DEPTH x WIDTH async-reset registers with a one-hot write-enable decode from wr_ptr and a read mux on rd_ptr.

Verification
REQ-033 Reset, then rd_en=1 for one cycle -> rd_err=1, empty=1, d_out=0, data_count=0.
REQ-034 DEPTH=8: write 0x11..0x88 -> full=1, data_count=8; a ninth write of 0x99 -> wr_err=1 and contents unchanged.
REQ-035 Read 8 times -> d_out sequence 0x11..0x88, each value one cycle after its rd_en; then empty=1.
REQ-036 Fill 5, read 5, write 6 more -> pointers wrap past 7, and the read-back order is preserved.
REQ-037 Simultaneous wr_en/rd_en when empty, when holding 3 entries, and when full -> responses per REQ-022, REQ-020 and REQ-021, with counts 1, 3 and 7.
REQ-038 With PARAM_FIFO_ALMOST_FLAGS_EN and AF_LEVEL=6, AE_LEVEL=1 -> almost_full rises at count 6, almost_empty falls at count 2; reset_n pulsed low at count 4 -> all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// Shared types and default sizing for the parameterised FIFO.
package param_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 8;

  // Each state records how the previous cycle's request pair was resolved.
  typedef enum logic [3:0] {
    INIT,
    NO_OP,
    WRITE,
    WR_ERR,
    READ,
    RD_ERR,
    WR_RD,
    WR_RDERR,
    RD_WRERR
  } state_e;

endpackage

// File: rtl/param_fifo_regbank.sv
// DEPTH x WIDTH register storage: one-hot write decode, async read mux.
module param_fifo_regbank
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rd_data_c
);

  logic [DEPTH-1:0] wr_sel;
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_q [DEPTH];

  // One-hot entry select for the accepted write.
  always_comb begin
    wr_sel = DEPTH'(wr_en) << wr_ptr;
  end

  // Next contents: only the selected entry takes the write data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = wr_sel[i] ? wr_data : mem_q[i];
    end
  end

  // Storage registers, cleared by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data_c = mem_q[rd_ptr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with ack/err result pulses and occupancy count.
// Optional almost_full/almost_empty flags: define PARAM_FIFO_ALMOST_FLAGS_EN.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       d_in,
  output logic [WIDTH-1:0]       d_out,
  output logic                   full,
  output logic                   empty,
  output logic                   wr_ack,
  output logic                   wr_err,
  output logic                   rd_ack,
  output logic                   rd_err,
  output logic [$clog2(DEPTH):0] data_count
`ifdef PARAM_FIFO_ALMOST_FLAGS_EN
  ,
  output logic                   almost_full,
  output logic                   almost_empty
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("param_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_levels
    $error("param_fifo: AF_LEVEL/AE_LEVEL must not exceed DEPTH");
  end

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] d_out_q, d_out_d;
  logic [WIDTH-1:0] rd_data_c;
  logic             full_c, empty_c, wr_accept_c, rd_accept_c;

  assign full_c      = (count_q == CNT_W'(DEPTH));
  assign empty_c     = (count_q == '0);
  assign wr_accept_c = wr_en && !full_c;
  assign rd_accept_c = rd_en && !empty_c;

  // Next state: classify this cycle's request pair against current occupancy.
  always_comb begin
    state_d = NO_OP;
    case ({wr_en, rd_en})
      2'b11: begin
        if (empty_c)     state_d = WR_RDERR;
        else if (full_c) state_d = RD_WRERR;
        else             state_d = WR_RD;
      end
      2'b10:   state_d = full_c  ? WR_ERR : WRITE;
      2'b01:   state_d = empty_c ? RD_ERR : READ;
      default: state_d = NO_OP;
    endcase
  end

  // Pointer, count and read-data updates for accepted requests.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    d_out_d  = d_out_q;
    if (wr_accept_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_accept_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      d_out_d  = rd_data_c;
    end
    case ({wr_accept_c, rd_accept_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      d_out_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      d_out_q  <= d_out_d;
    end
  end

  param_fifo_regbank #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regbank (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (wr_accept_c),
    .wr_ptr    (wr_ptr_q),
    .wr_data   (d_in),
    .rd_ptr    (rd_ptr_q),
    .rd_data_c (rd_data_c)
  );

  assign d_out      = d_out_q;
  assign data_count = count_q;
  assign full       = full_c;
  assign empty      = empty_c;

  // Result pulses decoded from the registered state.
  assign wr_ack = (state_q inside {WRITE, WR_RD, WR_RDERR});
  assign wr_err = (state_q inside {WR_ERR, RD_WRERR});
  assign rd_ack = (state_q inside {READ, WR_RD, RD_WRERR});
  assign rd_err = (state_q inside {RD_ERR, WR_RDERR});

`ifdef PARAM_FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
`endif

endmodule
